// File: rtl/digit_raster_renderer.sv
// digit_raster_renderer
//
// Draws a horizontal row of BCD digits into the VGA pixel stream. Each
// digit uses a 5x7 font in which every font pixel is scaled up to a
// 2^SCALE_LOG2 square of screen pixels. Digit values and the blink mask are
// captured once per frame so that the picture never tears. Digits selected
// in the mask blink with a half-period of BLINK_FRAMES frames.
//
// The design is a 3-stage pipeline: offset/divide, font lookup, colour.
// Colour and out_valid appear exactly 3 clocks after row/column/pixel_valid.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high
//   frame_start  one-cycle pulse at the start of each frame
//   digits       4*NUM_DIGITS BCD nibbles; the MS nibble is digit 0 (leftmost)
//   blink_mask   NUM_DIGITS bits; the MS bit is digit 0
//   pixel_valid  row/column are valid this cycle
//   row, column  current screen coordinate
//   r, g, b      registered pixel colour
//   out_valid    pixel_valid delayed by the pipeline latency

module digit_raster_renderer #(
  parameter int          NUM_DIGITS   = 8,
  parameter int          SCALE_LOG2   = 2,
  parameter int          ORIGIN_X     = 125,
  parameter int          ORIGIN_Y     = 200,
  parameter logic [2:0]  FG_COLOR     = 3'b010,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    pixel_valid,
  input  logic [15:0]             row,
  input  logic [15:0]             column,
  output logic                    r,
  output logic                    g,
  output logic                    b,
  output logic                    out_valid
);

  localparam int SCALE  = 1 << SCALE_LOG2;
  localparam int WIDTH  = NUM_DIGITS * 6 * SCALE;
  localparam int HEIGHT = 7 * SCALE;
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Font rows for one glyph: row 0 at the top, bit 4 is the leftmost pixel.
  // Anything other than 0..9, or a row index of 7, draws nothing.
  function automatic logic [4:0] font_lookup(input logic [3:0] nib,
                                             input logic [2:0] y);
    logic [34:0] glyph;
    logic [4:0]  bits;
    glyph = '0;
    case (nib)
      4'd0: glyph = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
      4'd1: glyph = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      4'd2: glyph = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
      4'd3: glyph = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
      4'd4: glyph = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
      4'd5: glyph = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
      4'd6: glyph = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
      4'd7: glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
      4'd8: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
      4'd9: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
      default: glyph = '0;
    endcase
    case (y)
      3'd0:    bits = glyph[34:30];
      3'd1:    bits = glyph[29:25];
      3'd2:    bits = glyph[24:20];
      3'd3:    bits = glyph[19:15];
      3'd4:    bits = glyph[14:10];
      3'd5:    bits = glyph[9:5];
      3'd6:    bits = glyph[4:0];
      default: bits = '0;
    endcase
    return bits;
  endfunction

  // Per-frame snapshot and blink state
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_mask_q, snap_mask_d;
  logic [CNT_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  // Stage 1 registers
  logic       valid_s1_q, valid_s1_d;
  logic       inside_q, inside_d;
  logic [3:0] index_q, index_d;
  logic [2:0] glyph_col_q, glyph_col_d;
  logic [2:0] gy_q, gy_d;

  // Stage 2 registers
  logic valid_s2_q, valid_s2_d;
  logic lit_q, lit_d;
  logic hidden_q, hidden_d;

  // Stage 3 registers
  logic [2:0] rgb_q, rgb_d;
  logic       out_valid_q, out_valid_d;

  // Stage 1 intermediates
  logic [16:0] dx;
  logic [16:0] dy;
  logic [15:0] gx;

  // Stage 2 intermediates
  logic [3:0] nibble;
  logic       mask_bit;
  logic [4:0] font_row;
  logic       font_bit;

  // Snapshot loads only on frame_start so mid-frame digit changes stay
  // invisible. The blink counter advances once per frame and flips the
  // phase each time it wraps.
  always_comb begin
    snap_digits_d = snap_digits_q;
    snap_mask_d   = snap_mask_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      snap_digits_d = digits;
      snap_mask_d   = blink_mask;
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 1: offset from the origin, region test, and scale-down.
  // The 17-bit subtraction puts the sign in bit 16, so coordinates left of
  // or above the origin read as negative and are rejected.
  // The digit index is gx/6, built as a comparator ladder against multiples
  // of 6; the glyph column is the remainder.
  always_comb begin
    dx          = {1'b0, column} - 17'(ORIGIN_X);
    dy          = {1'b0, row} - 17'(ORIGIN_Y);
    inside_d    = !dx[16] && (dx[15:0] < 16'(WIDTH)) &&
                  !dy[16] && (dy[15:0] < 16'(HEIGHT));
    gx          = dx[15:0] >> SCALE_LOG2;
    index_d     = '0;
    for (int i = 1; i < 16; i++) begin
      if (gx >= 16'(6 * i)) index_d = 4'(i);
    end
    glyph_col_d = 3'(gx - 16'(6) * {12'd0, index_d});
    gy_d        = 3'(dy[15:0] >> SCALE_LOG2);
    valid_s1_d  = pixel_valid;
  end

  // Stage 2: pick the snapshot nibble and its blink bit, then look up the
  // font row. Glyph column 5 is the inter-digit gap and is never lit.
  always_comb begin
    nibble   = 4'hF;
    mask_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == 4'(i)) begin
        nibble   = snap_digits_q[4*(NUM_DIGITS-1-i) +: 4];
        mask_bit = snap_mask_q[NUM_DIGITS-1-i];
      end
    end
    font_row = font_lookup(nibble, gy_q);
    case (glyph_col_q)
      3'd0:    font_bit = font_row[4];
      3'd1:    font_bit = font_row[3];
      3'd2:    font_bit = font_row[2];
      3'd3:    font_bit = font_row[1];
      3'd4:    font_bit = font_row[0];
      default: font_bit = 1'b0;
    endcase
    lit_d      = inside_q & font_bit;
    hidden_d   = mask_bit & blink_phase_q;
    valid_s2_d = valid_s1_q;
  end

  // Stage 3: final colour, black unless the pixel is valid, lit and visible.
  always_comb begin
    rgb_d       = (lit_q && !hidden_q && valid_s2_q) ? FG_COLOR : 3'b000;
    out_valid_d = valid_s2_q;
  end

  // All state registers; reset wins over frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_digits_q <= {NUM_DIGITS{4'hF}};
      snap_mask_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      valid_s1_q    <= 1'b0;
      inside_q      <= 1'b0;
      index_q       <= '0;
      glyph_col_q   <= '0;
      gy_q          <= '0;
      valid_s2_q    <= 1'b0;
      lit_q         <= 1'b0;
      hidden_q      <= 1'b0;
      rgb_q         <= 3'b000;
      out_valid_q   <= 1'b0;
    end else begin
      snap_digits_q <= snap_digits_d;
      snap_mask_q   <= snap_mask_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      valid_s1_q    <= valid_s1_d;
      inside_q      <= inside_d;
      index_q       <= index_d;
      glyph_col_q   <= glyph_col_d;
      gy_q          <= gy_d;
      valid_s2_q    <= valid_s2_d;
      lit_q         <= lit_d;
      hidden_q      <= hidden_d;
      rgb_q         <= rgb_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign r         = rgb_q[2];
  assign g         = rgb_q[1];
  assign b         = rgb_q[0];
  assign out_valid = out_valid_q;

endmodule
